// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - serial input and BRAM write/status bundle of the program loader
interface prog_loader_if;
    logic        rxd;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    modport master (
        input  rxd,
        output ram_addr, ram_data, ram_we, cpu_hold, load_done, load_err
    );

    modport slave (
        output rxd,
        input  ram_addr, ram_data, ram_we, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - 8N1 UART receiver feeding a framed, checksummed program image into BRAM port B
module prog_loader #(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 115200,
    parameter logic [10:0] LOAD_BASE = 11'd0
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP}       rx_state_t;
    typedef enum logic [1:0] {F_HDR, F_LEN, F_DATA, F_SUM}   fr_state_t;

    // rxd_d is only an edge-detect delay behind the two-stage synchronizer
    logic rxd_s1, rxd_s2, rxd_d;
    logic fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= bus.rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign fall = rxd_d & ~rxd_s2;

    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tick;
    logic            rx_valid, rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        tick = 1'b0;
        case (rx_state)
            START:      tick = (cnt == CW'(HALF - 1));
            DATA, STOP: tick = (cnt == CW'(CPB - 1));
            default:    tick = 1'b0;
        endcase
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (fall) rx_next = START;
            START: if (tick) rx_next = rxd_s2 ? IDLE : DATA;
            DATA:  if (tick && bit_idx == 3'd7) rx_next = STOP;
            STOP:  if (tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        if (rx_state == STOP && tick) begin
            rx_valid = rxd_s2;
            rx_ferr  = ~rxd_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (rx_state == IDLE || tick) cnt <= '0;
            else                          cnt <= cnt + CW'(1);
            if (rx_state != DATA)         bit_idx <= 3'd0;
            else if (tick)                bit_idx <= bit_idx + 3'd1;
            if (rx_state == DATA && tick) shreg <= {rxd_s2, shreg[7:1]};
        end
    end

    fr_state_t   fr_state, fr_next;
    logic [8:0]  index, len;
    logic [7:0]  sum;
    logic        last;
    logic [10:0] ram_addr_q, ram_addr_n;
    logic [7:0]  ram_data_q, ram_data_n;
    logic        ram_we_q, ram_we_n;
    logic        cpu_hold_q, cpu_hold_n;
    logic        load_done_q, load_done_n;
    logic        load_err_q, load_err_n;

    assign last = (index + 9'd1 == len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fr_state <= F_HDR;
        else     fr_state <= fr_next;
    end

    always_comb begin
        fr_next = fr_state;
        case (fr_state)
            F_HDR:  if (rx_valid && shreg == 8'hA5) fr_next = F_LEN;
            F_LEN:  if (rx_valid) fr_next = F_DATA;
                    else if (rx_ferr) fr_next = F_HDR;
            F_DATA: if (rx_valid && last) fr_next = F_SUM;
                    else if (rx_ferr) fr_next = F_HDR;
            F_SUM:  if (rx_valid || rx_ferr) fr_next = F_HDR;
            default: fr_next = F_HDR;
        endcase
    end

    // Next values of the registered outputs; everything lands one cycle after rx_valid
    always_comb begin
        ram_addr_n  = ram_addr_q;
        ram_data_n  = ram_data_q;
        ram_we_n    = 1'b0;
        cpu_hold_n  = cpu_hold_q;
        load_done_n = 1'b0;
        load_err_n  = load_err_q;
        if (fr_state == F_HDR) begin
            if (rx_valid && shreg == 8'hA5) begin
                cpu_hold_n = 1'b1;
                load_err_n = 1'b0;
            end
        end else if (rx_ferr) begin
            cpu_hold_n = 1'b0;
            load_err_n = 1'b1;
        end else if (rx_valid) begin
            if (fr_state == F_DATA) begin
                ram_addr_n = LOAD_BASE + {2'b00, index};
                ram_data_n = shreg;
                ram_we_n   = 1'b1;
            end else if (fr_state == F_SUM) begin
                cpu_hold_n = 1'b0;
                if (shreg == sum) load_done_n = 1'b1;
                else              load_err_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= 11'd0;
            ram_data_q  <= 8'h00;
            ram_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            index       <= 9'd0;
            len         <= 9'd0;
            sum         <= 8'h00;
        end else begin
            ram_addr_q  <= ram_addr_n;
            ram_data_q  <= ram_data_n;
            ram_we_q    <= ram_we_n;
            cpu_hold_q  <= cpu_hold_n;
            load_done_q <= load_done_n;
            load_err_q  <= load_err_n;
            if (rx_valid) begin
                if (fr_state == F_HDR && shreg == 8'hA5) begin
                    index <= 9'd0;
                    sum   <= 8'h00;
                end else if (fr_state == F_LEN) begin
                    len <= (shreg == 8'h00) ? 9'd256 : {1'b0, shreg};
                end else if (fr_state == F_DATA) begin
                    index <= index + 9'd1;
                    sum   <= sum + shreg;
                end
            end
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_data  = ram_data_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;
endmodule
